// File: rtl/display_pkg.sv
// Shared constants for the output display: controller states, BCD sizing
// and the common-cathode segment patterns (bit0=a .. bit6=g, bit7=dp).
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam int unsigned BCD_DIGITS      = 3;
  localparam int unsigned BCD_WIDTH       = 4 * BCD_DIGITS;
  localparam int unsigned CONV_ITERATIONS = 8;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational map from a digit code (0-9, 0xA minus, anything else blank)
// to active-high segment bits; the decimal point is never lit.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (code)
      4'h0:       segments = SEG_0;
      4'h1:       segments = SEG_1;
      4'h2:       segments = SEG_2;
      4'h3:       segments = SEG_3;
      4'h4:       segments = SEG_4;
      4'h5:       segments = SEG_5;
      4'h6:       segments = SEG_6;
      4'h7:       segments = SEG_7;
      4'h8:       segments = SEG_8;
      4'h9:       segments = SEG_9;
      CODE_MINUS: segments = SEG_MINUS;
      default:    segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/output_display.sv
// OUT register with sequential double-dabble conversion and a 4-digit
// multiplexed common-cathode 7-segment scan driver.
module output_display
  import display_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic                  i_CLOCK,
  input  logic                  i_CLEAR_n,
  input  logic                  i_OUT_IN,
  input  logic [DATA_WIDTH-1:0] i_BUS_DATA,
  input  logic                  i_SIGNED,
  output logic [DATA_WIDTH-1:0] o_VALUE,
  output logic                  o_BUSY,
  output logic [3:0]            o_DIGIT_EN,
  output logic [7:0]            o_SEGMENTS
);

  localparam int unsigned SHIFT_W = BCD_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(REFRESH_DIV);
  localparam int unsigned ITER_W  = $clog2(CONV_ITERATIONS) + 1;

  state_t              state;
  logic                neg;
  logic [SHIFT_W-1:0]  shift;
  logic [SHIFT_W-1:0]  dd_adj;
  logic [SHIFT_W-1:0]  dd_next;
  logic [ITER_W-1:0]   iter;
  logic [3:0]          disp [4];

  logic                  load_neg;
  logic [DATA_WIDTH-1:0] load_mag;
  logic [3:0]            hundreds;
  logic [3:0]            tens;
  logic [3:0]            ones;

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       digit_idx;
  logic [3:0]       mux_code;
  logic [7:0]       dec_seg;

  assign load_neg = i_SIGNED & i_BUS_DATA[DATA_WIDTH-1];
  assign load_mag = load_neg ? (~i_BUS_DATA + DATA_WIDTH'(1)) : i_BUS_DATA;

  assign hundreds = shift[SHIFT_W-1 -: 4];
  assign tens     = shift[SHIFT_W-5 -: 4];
  assign ones     = shift[SHIFT_W-9 -: 4];

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  always_comb begin
    dd_adj = shift;
    for (int unsigned n = 0; n < BCD_DIGITS; n++) begin
      if (dd_adj[DATA_WIDTH + 4*n +: 4] >= 4'd5)
        dd_adj[DATA_WIDTH + 4*n +: 4] = dd_adj[DATA_WIDTH + 4*n +: 4] + 4'd3;
    end
    dd_next = {dd_adj[SHIFT_W-2:0], 1'b0};
  end

  // The display registers only change at COMMIT, so a reload mid-conversion
  // never exposes partial BCD results.
  always_ff @(posedge i_CLOCK) begin
    if (!i_CLEAR_n) begin
      state   <= IDLE;
      o_VALUE <= '0;
      o_BUSY  <= 1'b0;
      neg     <= 1'b0;
      shift   <= '0;
      iter    <= '0;
      disp[3] <= CODE_BLANK;
      disp[2] <= CODE_BLANK;
      disp[1] <= CODE_BLANK;
      disp[0] <= 4'h0;
    end else if (i_OUT_IN) begin
      o_VALUE <= i_BUS_DATA;
      neg     <= load_neg;
      shift   <= SHIFT_W'(load_mag);
      iter    <= '0;
      state   <= CONVERT;
      o_BUSY  <= 1'b1;
    end else begin
      case (state)
        CONVERT: begin
          shift <= dd_next;
          iter  <= iter + ITER_W'(1);
          if (iter == ITER_W'(CONV_ITERATIONS - 1))
            state <= COMMIT;
        end
        COMMIT: begin
          disp[3] <= neg ? CODE_MINUS : CODE_BLANK;
          disp[2] <= (hundreds == 4'h0) ? CODE_BLANK : hundreds;
          disp[1] <= (hundreds == 4'h0 && tens == 4'h0) ? CODE_BLANK : tens;
          disp[0] <= ones;
          state   <= IDLE;
          o_BUSY  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mux_code = disp[digit_idx];

  seg7_decoder u_seg7_decoder (
    .code     (mux_code),
    .segments (dec_seg)
  );

  always_ff @(posedge i_CLOCK) begin
    if (!i_CLEAR_n) begin
      scan_cnt   <= '0;
      digit_idx  <= 2'd0;
      o_DIGIT_EN <= 4'b0001;
      o_SEGMENTS <= SEG_0;
    end else begin
      o_DIGIT_EN <= 4'b0001 << digit_idx;
      o_SEGMENTS <= dec_seg;
      if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_output_display.sv
// Self-checking bench for output_display: a decimal-arithmetic model checked
// every cycle, plus literal expectations for each displayed value.
module tb_output_display;

  localparam int unsigned DW  = 8;
  localparam int unsigned DIV = 4;

  logic          clk;
  logic          clear_n;
  logic          out_in;
  logic [DW-1:0] bus;
  logic          sgn;
  logic [DW-1:0] value;
  logic          busy;
  logic [3:0]    digit_en;
  logic [7:0]    segments;

  output_display #(.DATA_WIDTH(DW), .REFRESH_DIV(DIV)) dut (
    .i_CLOCK    (clk),
    .i_CLEAR_n  (clear_n),
    .i_OUT_IN   (out_in),
    .i_BUS_DATA (bus),
    .i_SIGNED   (sgn),
    .o_VALUE    (value),
    .o_BUSY     (busy),
    .o_DIGIT_EN (digit_en),
    .o_SEGMENTS (segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] segtab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // Behavioural model: digits from integer division, busy as a countdown.
  bit         m_valid = 0;
  logic [7:0] m_value;
  int         m_left;
  logic [7:0] m_disp [4];
  logic [7:0] m_pend [4];
  int         m_cnt;
  int         m_idx;
  logic [3:0] m_en;
  logic [7:0] m_seg;

  always @(posedge clk) begin
    if (!clear_n) begin
      m_valid = 1;
      m_value = 8'h00;
      m_left  = 0;
      m_disp  = '{8'h3F, 8'h00, 8'h00, 8'h00};
      m_cnt   = 0;
      m_idx   = 0;
      m_en    = 4'b0001;
      m_seg   = 8'h3F;
    end else if (m_valid) begin
      m_en  = 4'b0001 << m_idx;
      m_seg = m_disp[m_idx];
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
      if (out_in) begin
        int mag, h, t, o;
        bit n;
        m_value = bus;
        n   = sgn && bus[7];
        mag = n ? 256 - int'(bus) : int'(bus);
        h   = mag / 100;
        t   = (mag / 10) % 10;
        o   = mag % 10;
        m_pend[3] = n ? 8'h40 : 8'h00;
        m_pend[2] = (h != 0) ? segtab[h] : 8'h00;
        m_pend[1] = (h != 0 || t != 0) ? segtab[t] : 8'h00;
        m_pend[0] = segtab[o];
        m_left = 9;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_disp = m_pend;
      end
    end
  end

  bit watch5 = 0;
  bit saw5   = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("value",    value,    m_value);
      chk("busy",     busy,     m_left != 0);
      chk("digit_en", digit_en, m_en);
      chk("segments", segments, m_seg);
      chk("onehot",   $onehot(digit_en), 1);
      if (watch5 && digit_en == 4'b0001 && segments == 8'h6D) saw5 = 1;
    end
  end

  logic [7:0] cap [4];

  task automatic capture();
    logic [3:0] seen = 4'h0;
    for (int i = 0; i < 40 && seen != 4'hF; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (digit_en == (4'b0001 << k)) begin
          cap[k]  = segments;
          seen[k] = 1'b1;
        end
      end
    end
    chk("capture_complete", seen, 4'hF);
  endtask

  task automatic expect_display(input string tag, input logic [7:0] e3, e2, e1, e0);
    capture();
    chk({tag, "_d3"}, cap[3], e3);
    chk({tag, "_d2"}, cap[2], e2);
    chk({tag, "_d1"}, cap[1], e1);
    chk({tag, "_d0"}, cap[0], e0);
    chk({tag, "_model_d3"}, m_disp[3], e3);
    chk({tag, "_model_d0"}, m_disp[0], e0);
  endtask

  // Called at a negedge; the load is sampled at the following posedge.
  task automatic load(input logic [7:0] d, input logic s);
    out_in = 1'b1;
    bus    = d;
    sgn    = s;
    @(negedge clk);
    out_in = 1'b0;
    bus    = $urandom_range(255);
    sgn    = $urandom_range(1);
  endtask

  task automatic busy_len(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, 9);
  endtask

  task automatic run_case(input string tag, input logic [7:0] d, input logic s,
                          input logic [7:0] e3, e2, e1, e0);
    load(d, s);
    busy_len(tag);
    chk({tag, "_value"}, value, d);
    expect_display(tag, e3, e2, e1, e0);
  endtask

  initial begin
    clear_n = 1'b0;
    out_in  = 1'b0;
    bus     = '0;
    sgn     = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_en",    digit_en, 4'b0001);
    chk("reset_seg",   segments, 8'h3F);
    chk("reset_busy",  busy,     1'b0);
    chk("reset_value", value,    8'h00);
    clear_n = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    expect_display("idle", 8'h00, 8'h00, 8'h00, 8'h3F);

    run_case("u7B", 8'h7B, 1'b0, 8'h00, 8'h06, 8'h5B, 8'h4F);
    run_case("sFF", 8'hFF, 1'b1, 8'h40, 8'h00, 8'h00, 8'h06);
    run_case("s80", 8'h80, 1'b1, 8'h40, 8'h06, 8'h5B, 8'h7F);
    run_case("u80", 8'h80, 1'b0, 8'h00, 8'h06, 8'h5B, 8'h7F);

    watch5 = 1;
    load(8'h05, 1'b0);
    repeat (2) @(negedge clk);
    load(8'hC8, 1'b0);
    busy_len("reload");
    chk("reload_value", value, 8'hC8);
    expect_display("reload", 8'h00, 8'h5B, 8'h3F, 8'h3F);
    watch5 = 0;
    chk("reload_no_5", saw5, 1'b0);

    load(8'h99, 1'b0);
    repeat (3) @(negedge clk);
    clear_n = 1'b0;
    out_in  = 1'b1;
    bus     = 8'h42;
    @(negedge clk);
    clear_n = 1'b1;
    out_in  = 1'b0;
    chk("clr_busy",  busy,  1'b0);
    chk("clr_value", value, 8'h00);
    expect_display("clr", 8'h00, 8'h00, 8'h00, 8'h3F);

    run_case("u00", 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h3F);
    run_case("u0A", 8'h0A, 1'b0, 8'h00, 8'h00, 8'h06, 8'h3F);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
